// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one word-wide UART transmitter between two requesters.
// Define UART_ARB_FIFO_EN to give port 0 a FIFO_DEPTH-word FIFO instead of a 1-entry register.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [31:0] tx_sdata,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        busy,
  output logic        grant_id,
  output logic        err
);
  // IDLE: pick a pending port | ISSUE: one-cycle start pulse | WAIT_DONE: wait for tx_done or watchdog
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  localparam logic [31:0] CNT_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] sdata_q, sdata_d;
  logic        grant_q, grant_d;
  logic        err_q, err_d;

  logic        pend0, pend1;
  logic [31:0] head0;
  logic        pop0, pop1;
  logic [31:0] hold1_q;
  logic        hold1_vld_q;

`ifdef UART_ARB_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [31:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        full0, push0;

  // Extra pointer bit tells full from empty when the indices match.
  assign full0      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pend0      = (wr_q != rd_q);
  assign req0_ready = !full0;
  assign push0      = req0_valid && !full0;
  assign head0      = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_q[AW-1:0]] <= req0_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push0) wr_q <= wr_q + 1'b1;
      if (pop0)  rd_q <= rd_q + 1'b1;
    end
  end
`else
  logic [31:0] hold0_q;
  logic        hold0_vld_q;

  assign req0_ready = !hold0_vld_q;
  assign pend0      = hold0_vld_q;
  assign head0      = hold0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold0_q     <= '0;
      hold0_vld_q <= 1'b0;
    end else if (req0_valid && !hold0_vld_q) begin
      hold0_q     <= req0_data;
      hold0_vld_q <= 1'b1;
    end else if (pop0) begin
      hold0_vld_q <= 1'b0;
    end
  end
`endif

  assign req1_ready = !hold1_vld_q;
  assign pend1      = hold1_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold1_q     <= '0;
      hold1_vld_q <= 1'b0;
    end else if (req1_valid && !hold1_vld_q) begin
      hold1_q     <= req1_data;
      hold1_vld_q <= 1'b1;
    end else if (pop1) begin
      hold1_vld_q <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sdata_d  = sdata_q;
    grant_d  = grant_q;
    err_d    = err_q;
    pop0     = 1'b0;
    pop1     = 1'b0;
    tx_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((pend0 || pend1) && !tx_busy) begin
          // On a tie, the port that did not own the last transfer wins.
          if (pend0 && (!pend1 || grant_q)) begin
            pop0    = 1'b1;
            sdata_d = head0;
            grant_d = 1'b0;
          end else begin
            pop1    = 1'b1;
            sdata_d = hold1_q;
            grant_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        tx_start = 1'b1;
        cnt_d    = '0;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LIMIT) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sdata_q <= '0;
      grant_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sdata_q <= sdata_d;
      grant_q <= grant_d;
      err_q   <= err_d;
    end
  end

  assign tx_sdata = sdata_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
  assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: main instance at default timeout, second instance with a 16-cycle watchdog.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        tx_busy = 1'b0, tx_done = 1'b0;

  logic        req0_ready, req1_ready, tx_start, busy, grant_id, err;
  logic [31:0] tx_sdata;
  logic        w_req0_ready, w_req1_ready, w_tx_start, w_busy, w_grant_id, w_err;
  logic [31:0] w_tx_sdata;

  int n_cmp = 0;
  int n_bad = 0;
  int n_starts = 0;
  logic [32:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_sdata(tx_sdata), .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut_wd (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(w_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(w_req1_ready),
    .tx_sdata(w_tx_sdata), .tx_start(w_tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .busy(w_busy), .grant_id(w_grant_id), .err(w_err)
  );

  always @(posedge clk) if (tx_start === 1'b1) n_starts++;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "bench timeout");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tx_done    = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_start(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (tx_start === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  // Done is high in the cycle that lies `delay` cycles after the current one; returns in IDLE.
  task automatic finish_word(input int delay);
    repeat (delay) step();
    tx_done = 1'b1;
    tx_busy = 1'b0;
    step();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++;
    if ({req0_ready, req1_ready, tx_start, busy, grant_id, err} !== 6'b110010) begin
      n_bad++;
      $display("FAIL reset_flags got %b, want 110010", {req0_ready, req1_ready, tx_start, busy, grant_id, err});
    end
    n_cmp++;
    if (tx_sdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_sdata got %h, want 00000000", tx_sdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    int cyc, s0;
    logic [32:0] e;
    do_reset();
    s0 = n_starts;
    req0_valid = 1'b1;
    req0_data  = 32'hDEADBEEF;
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    step();
    req0_valid = 1'b0;
    n_cmp++;
    if (req0_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ready_full got %b, want 0", req0_ready);
    end
    wait_start(10, cyc);
    n_cmp++;
    if (cyc != 1) begin
      n_bad++;
      $display("FAIL single_latency got %0d, want 1", cyc);
    end
    n_cmp++;
    if (req0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL single_ready_freed got %b, want 1", req0_ready);
    end
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    n_cmp++;
    if ({grant_id, tx_sdata} !== e) begin
      n_bad++;
      $display("FAIL single_word got grant=%0d data=%h, want grant=%0d data=%h", grant_id, tx_sdata, e[32], e[31:0]);
    end
    tx_busy = 1'b1;
    step();
    n_cmp++;
    if ({tx_start, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL single_pulse_width got start/busy=%b, want 01", {tx_start, busy});
    end
    repeat (39) step();
    tx_done = 1'b1;
    tx_busy = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL single_busy_at_done got %b, want 1", busy);
    end
    step();
    tx_done = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL single_busy_after_done got %b, want 0", busy);
    end
    repeat (5) step();
    n_cmp++;
    if (n_starts - s0 != 1) begin
      n_bad++;
      $display("FAIL single_start_count got %0d, want 1", n_starts - s0);
    end
  endtask

  task automatic test_contention();
    int cyc, s0;
    logic [32:0] e;
    logic [31:0] w0 [2];
    logic [31:0] w1 [2];
    w0[0] = 32'h11111111; w1[0] = 32'h22222222;
    w0[1] = 32'h33333333; w1[1] = 32'h44444444;
    do_reset();
    s0 = n_starts;
    for (int r = 0; r < 2; r++) begin
      req0_valid = 1'b1; req0_data = w0[r];
      req1_valid = 1'b1; req1_data = w1[r];
      exp_q.push_back({1'b0, w0[r]});
      exp_q.push_back({1'b1, w1[r]});
      step();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      for (int j = 0; j < 2; j++) begin
        wait_start(10, cyc);
        n_cmp++;
        if (cyc != 1) begin
          n_bad++;
          $display("FAIL cont_gap round=%0d word=%0d got %0d, want 1", r, j, cyc);
        end
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        n_cmp++;
        if ({grant_id, tx_sdata} !== e) begin
          n_bad++;
          $display("FAIL cont_word round=%0d got grant=%0d data=%h, want grant=%0d data=%h", r, grant_id, tx_sdata, e[32], e[31:0]);
        end
        tx_busy = 1'b1;
        finish_word(5);
      end
    end
    n_cmp++;
    if (n_starts - s0 != 4) begin
      n_bad++;
      $display("FAIL cont_start_count got %0d, want 4", n_starts - s0);
    end
  endtask

  task automatic test_backpressure();
    int s0;
    logic [31:0] w [3];
    w[0] = 32'hCAFE0001; w[1] = 32'hCAFE0002; w[2] = 32'hCAFE0003;
    do_reset();
    s0 = n_starts;
    fork
      begin : producer
        int waited;
        bit acc;
        for (int i = 0; i < 3; i++) begin
          req1_valid = 1'b1;
          req1_data  = w[i];
          exp_q.push_back({1'b1, w[i]});
          acc = 1'b0;
          waited = 0;
          for (int t = 0; t < 200 && !acc; t++) begin
            acc = req1_ready;
            if (!acc) waited++;
            step();
          end
          n_cmp++;
          if (!acc) begin
            n_bad++;
            $display("FAIL bp_accept word=%0d got no acceptance, want acceptance", i);
          end
          if (i == 1) begin
            n_cmp++;
            if (req1_ready !== 1'b0) begin
              n_bad++;
              $display("FAIL bp_ready_after_2nd got %b, want 0", req1_ready);
            end
          end
          if (i == 2) begin
            n_cmp++;
            if (waited < 10) begin
              n_bad++;
              $display("FAIL bp_stall_len got %0d cycles, want at least 10", waited);
            end
          end
        end
        req1_valid = 1'b0;
      end
      begin : transmitter
        int cyc;
        logic [32:0] e;
        for (int j = 0; j < 3; j++) begin
          wait_start(200, cyc);
          n_cmp++;
          if (cyc < 0) begin
            n_bad++;
            $display("FAIL bp_start_timeout word=%0d got none, want tx_start", j);
          end
          e = 'x;
          if (exp_q.size() != 0) e = exp_q.pop_front();
          n_cmp++;
          if ({grant_id, tx_sdata} !== e) begin
            n_bad++;
            $display("FAIL bp_word %0d got grant=%0d data=%h, want grant=%0d data=%h", j, grant_id, tx_sdata, e[32], e[31:0]);
          end
          tx_busy = 1'b1;
          finish_word(20);
        end
      end
    join
    repeat (5) step();
    n_cmp++;
    if (n_starts - s0 != 3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bp_totals got starts=%0d left=%0d, want starts=3 left=0", n_starts - s0, exp_q.size());
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    tx_busy = 1'b0;
    req0_valid = 1'b1; req0_data = 32'hA5A5A5A5;
    req1_valid = 1'b1; req1_data = 32'h5A5A5A5A;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    n_cmp++;
    if ({w_tx_start, w_grant_id, w_tx_sdata, w_req0_ready, w_req1_ready} !== {1'b1, 1'b0, 32'hA5A5A5A5, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL wd_first_issue got start=%b grant=%0d data=%h rdy=%b%b, want 1 0 a5a5a5a5 10",
               w_tx_start, w_grant_id, w_tx_sdata, w_req0_ready, w_req1_ready);
    end
    step();
    repeat (15) step();
    n_cmp++;
    if ({w_err, w_busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL wd_before_fire got err/busy=%b, want 01", {w_err, w_busy});
    end
    step();
    n_cmp++;
    if ({w_err, w_busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL wd_fire got err/busy=%b, want 10", {w_err, w_busy});
    end
    step();
    n_cmp++;
    if ({w_tx_start, w_grant_id, w_tx_sdata} !== {1'b1, 1'b1, 32'h5A5A5A5A}) begin
      n_bad++;
      $display("FAIL wd_next_issue got start=%b grant=%0d data=%h, want 1 1 5a5a5a5a", w_tx_start, w_grant_id, w_tx_sdata);
    end
    repeat (30) step();
    n_cmp++;
    if (w_err !== 1'b1) begin
      n_bad++;
      $display("FAIL wd_sticky got %b, want 1", w_err);
    end
    do_reset();
    n_cmp++;
    if (w_err !== 1'b0) begin
      n_bad++;
      $display("FAIL wd_clear_on_rst got %b, want 0", w_err);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, s0;
    logic [32:0] e;
    do_reset();
    tx_busy = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0BADF00D;
    exp_q.push_back({1'b0, 32'h0BADF00D});
    step();
    req0_valid = 1'b0;
    wait_start(10, cyc);
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    n_cmp++;
    if ({grant_id, tx_sdata} !== e) begin
      n_bad++;
      $display("FAIL rmid_first got grant=%0d data=%h, want grant=%0d data=%h", grant_id, tx_sdata, e[32], e[31:0]);
    end
    tx_busy = 1'b1;
    step();
    step();
    req0_valid = 1'b1; req0_data = 32'h12345678;
    req1_valid = 1'b1; req1_data = 32'h9ABCDEF0;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    n_cmp++;
    if ({req1_ready, busy} !== 2'b01) begin
      n_bad++;
      $display("FAIL rmid_loaded got ready1/busy=%b, want 01", {req1_ready, busy});
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({req0_ready, req1_ready, tx_start, busy, grant_id, err} !== 6'b110010 || tx_sdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rmid_reset_vals got flags=%b data=%h, want 110010 00000000",
               {req0_ready, req1_ready, tx_start, busy, grant_id, err}, tx_sdata);
    end
    rst = 1'b0;
    exp_q.delete();
    s0 = n_starts;
    req0_valid = 1'b1; req0_data = 32'h600DCAFE;
    exp_q.push_back({1'b0, 32'h600DCAFE});
    step();
    req0_valid = 1'b0;
    repeat (8) step();
    n_cmp++;
    if (n_starts != s0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rmid_wait_busy got starts=%0d busy=%b, want starts=0 busy=0", n_starts - s0, busy);
    end
    tx_busy = 1'b0;
    wait_start(5, cyc);
    n_cmp++;
    if (cyc != 1) begin
      n_bad++;
      $display("FAIL rmid_issue_latency got %0d, want 1", cyc);
    end
    e = 'x;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    n_cmp++;
    if ({grant_id, tx_sdata} !== e) begin
      n_bad++;
      $display("FAIL rmid_word got grant=%0d data=%h, want grant=%0d data=%h", grant_id, tx_sdata, e[32], e[31:0]);
    end
    tx_busy = 1'b1;
    finish_word(3);
  endtask

`ifdef UART_ARB_FIFO_EN
  task automatic test_fifo();
    int cyc, s0, k;
    logic [32:0] e;
    logic [31:0] f [6];
    for (int i = 0; i < 6; i++) f[i] = 32'hF0000000 + 32'(i);
    do_reset();
    tx_busy = 1'b0;
    s0 = n_starts;
    k = 0;
    for (int t = 0; t < 20 && k < 6; t++) begin
      req0_valid = 1'b1;
      req0_data  = f[k];
      if (tx_start === 1'b1) begin
        e = 'x;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        n_cmp++;
        if ({grant_id, tx_sdata} !== e) begin
          n_bad++;
          $display("FAIL fifo_first got grant=%0d data=%h, want grant=%0d data=%h", grant_id, tx_sdata, e[32], e[31:0]);
        end
        tx_busy = 1'b1;
      end
      if (req0_ready) begin
        exp_q.push_back({1'b0, f[k]});
        k++;
      end
      step();
    end
    n_cmp++;
    if (k != 5 || req0_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fifo_fill got accepted=%0d ready=%b, want accepted=5 ready=0", k, req0_ready);
    end
    exp_q.push_back({1'b0, f[5]});
    for (int j = 1; j < 6; j++) begin
      finish_word(4);
      wait_start(20, cyc);
      e = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      n_cmp++;
      if (cyc != 1 || {grant_id, tx_sdata} !== e) begin
        n_bad++;
        $display("FAIL fifo_drain %0d got cyc=%0d grant=%0d data=%h, want cyc=1 grant=%0d data=%h",
                 j, cyc, grant_id, tx_sdata, e[32], e[31:0]);
      end
      tx_busy = 1'b1;
      if (req0_valid && req0_ready) begin
        step();
        req0_valid = 1'b0;
      end
    end
    finish_word(4);
    repeat (5) step();
    n_cmp++;
    if (n_starts - s0 != 6 || exp_q.size() != 0 || req0_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL fifo_totals got starts=%0d left=%0d ready=%b, want 6 0 1", n_starts - s0, exp_q.size(), req0_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_contention();
    test_backpressure();
    test_watchdog();
    test_reset_mid();
`ifdef UART_ARB_FIFO_EN
    test_fifo();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
